dice_ram_1rw_arb: RTL

Round-robin arbiter that shares one single-port `dice_ram_1rw` between `NUM_REQ` requesters. Each requester issues reads or writes with a valid/ready handshake. Read data is returned one cycle after the grant on a per-requester response channel that supports backpressure. The block owns the RAM instance and sits between DICE core-side clients (e.g. operand fetch and writeback) and the storage array.

---
 rtl/dice_ram_arb_pkg.sv | 33 +++
 rtl/dice_ram_1rw.sv | 31 +++
 rtl/dice_ram_1rw_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/dice_ram_arb_pkg.sv
// Shared types and the grant picker for the dice_ram_1rw arbiter.
// Round-robin order is selected in the top by the DICE_RAM_ARB_RR_EN macro.
package dice_ram_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_RSP_PEND
  } arb_state_e;

  // The picker works on a fixed 32-bit field. Requesters above NUM_REQ are tied to zero,
  // so a scan over the whole field gives the same order as a scan over NUM_REQ bits.
  localparam int ARB_MAX_REQ = 32;
  localparam int ARB_PTR_W   = 5;

  // Returns a one-hot grant for the first set bit of valid, scanning upward from ptr with wrap.
  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(input logic [ARB_MAX_REQ-1:0] valid,
                                                     input logic [ARB_PTR_W-1:0]   ptr);
    logic [ARB_MAX_REQ-1:0] grant;
    logic                   found;
    logic [ARB_PTR_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_REQ; k++) begin
      idx = ptr + ARB_PTR_W'(k);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/dice_ram_1rw.sv
// Single-port RAM with a registered read port. Writes leave the read register untouched.
// The contents are not reset.
module dice_ram_1rw #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dice_ram_1rw_arb.sv
// Arbiter that shares one dice_ram_1rw between NUM_REQ requesters, with a backpressured read response.
// The arbitration order is round-robin when DICE_RAM_ARB_RR_EN is defined, and fixed lowest-index-first otherwise.
module dice_ram_1rw_arb
  import dice_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic [ID_W-1:0]       rsp_id_reg;
  logic                  rsp_done;
  logic                  read_blocked;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic                  grant_any;
  logic [ID_W-1:0]       winner;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // A new read can only be taken when the response register is free, or is being freed in this cycle.
  assign rsp_done     = (state_reg == ARB_RSP_PEND) && rsp_ready[rsp_id_reg];
  assign read_blocked = (state_reg == ARB_RSP_PEND) && !rsp_done;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign eligible[gi] = req_valid[gi] & (req_we[gi] | ~read_blocked);
  end

`ifdef DICE_RAM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_reg;
  assign grant = NUM_REQ'(rr_pick(ARB_MAX_REQ'(eligible), ARB_PTR_W'(rr_ptr_reg)));
`else
  assign grant = NUM_REQ'(rr_pick(ARB_MAX_REQ'(eligible), '0));
`endif

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    winner    = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        winner    = ID_W'(i);
        ram_we    = req_we[i];
        ram_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ARB_IDLE;
      rsp_valid_reg <= '0;
      rsp_id_reg    <= '0;
`ifdef DICE_RAM_ARB_RR_EN
      rr_ptr_reg    <= '0;
`endif
    end else begin
      if (grant_any && !ram_we) begin
        state_reg     <= ARB_RSP_PEND;
        rsp_id_reg    <= winner;
        rsp_valid_reg <= grant;
      end else if (rsp_done) begin
        state_reg     <= ARB_IDLE;
        rsp_valid_reg <= '0;
      end
`ifdef DICE_RAM_ARB_RR_EN
      if (grant_any) begin
        rr_ptr_reg <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
`endif
    end
  end

  dice_ram_1rw #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (grant_any),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign rsp_valid = rsp_valid_reg;
  // The RAM read register is not reset, so the data bus is forced to zero whenever no response is held.
  assign rsp_rdata = (state_reg == ARB_RSP_PEND) ? ram_rdata : '0;

endmodule
